// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its lane mux.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_NONE    = 4'b0000;

   localparam int DMEM_WAIT_W = 4;

   // One outstanding request: word index plus the store/load attributes.
   typedef struct packed {
      logic        write;
      logic [3:0]  be;
      logic [29:0] idx;
      logic [31:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the processor datapath (master) and the data-memory responder (slave).
// Handshake: master raises req with fields stable and holds them until ready; ready is a one-cycle completion pulse, err coincides with it.
interface dmem_responder_if;
   logic        req;
   logic        MemWrite;
   logic [3:0]  be;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        ready;
   logic        err;

   modport master (
      output req, MemWrite, be, Addr, WriteData,
      input  ReadData, ready, err
   );

   modport slave (
      input  req, MemWrite, be, Addr, WriteData,
      output ReadData, ready, err
   );
endinterface

// File: rtl/dmem_responder_lane_mux.sv
// Load-lane selection: masks unselected byte lanes and, with DMEM_LOAD_ALIGN_EN, right-justifies byte/half loads.
module dmem_lane_mux
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [3:0]  be,
   output logic [31:0] data
);

   logic [31:0] masked;

   always_comb begin
      masked = '0;
      if (be == BE_WORD) begin
         masked = word;
      end else if (be != BE_NONE) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) masked[8*i +: 8] = word[8*i +: 8];
         end
      end
   end

`ifdef DMEM_LOAD_ALIGN_EN
   always_comb begin
      case (be)
         4'b0001:    data = {24'd0, masked[7:0]};
         4'b0010:    data = {24'd0, masked[15:8]};
         4'b0100:    data = {24'd0, masked[23:16]};
         4'b1000:    data = {24'd0, masked[31:24]};
         BE_HALF_LO: data = {16'd0, masked[15:0]};
         BE_HALF_HI: data = {16'd0, masked[31:16]};
         default:    data = masked;
      endcase
   end
`else
   assign data = masked;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, byte-lane writes and masked loads.
// Optional DMEM_LOAD_ALIGN_EN right-justifies byte/half loads (see dmem_lane_mux).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   dmem_responder_if.slave   bus,
   output dmem_state_t       dbg_state
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [DMEM_WAIT_W-1:0] CNT_INIT =
      (WAIT_CYCLES == 0) ? '0 : DMEM_WAIT_W'(WAIT_CYCLES - 1);

   dmem_state_t            state, state_nxt;
   logic [DMEM_WAIT_W-1:0] cnt, cnt_nxt;
   dmem_req_t              lat, inp, src;
   logic                   accept, enter_resp;
   logic                   src_hit, lat_hit, we;
   logic [IDX_W-1:0]       mem_idx;
   logic [31:0]            rd_word, rd_lanes, rd_q;
   logic [31:0]            mem [DEPTH_WORDS];
   logic                   unused_addr_lsb;

   assign inp = '{write: bus.MemWrite, be: bus.be, idx: bus.Addr[31:2], wdata: bus.WriteData};
   assign unused_addr_lsb = ^bus.Addr[1:0];

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      accept     = 1'b0;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_nxt = cnt - DMEM_WAIT_W'(1);
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The access happens on the edge entering RESP so ReadData is already valid while ready is high.
   // With no wait states that edge is also the acceptance edge, hence the live-input bypass.
   assign src     = (state == IDLE) ? inp : lat;
   assign src_hit = ({2'b00, src.idx} < 32'(DEPTH_WORDS));
   assign lat_hit = ({2'b00, lat.idx} < 32'(DEPTH_WORDS));
   assign mem_idx = src.idx[IDX_W-1:0];
   assign rd_word = mem[mem_idx];
   assign we      = enter_resp && src.write && src_hit && reset;

   dmem_lane_mux u_lane_mux (
      .word (rd_word),
      .be   (src.be),
      .data (rd_lanes)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         lat   <= '0;
         rd_q  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) lat <= inp;
         if (enter_resp && !src.write) rd_q <= src_hit ? rd_lanes : '0;
      end
   end

   // Array contents survive reset; the write strobe is gated so an abandoned store never lands.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (src.be[i]) mem[mem_idx][8*i +: 8] <= src.wdata[8*i +: 8];
         end
      end
   end

   assign bus.ReadData = rd_q;
   assign bus.ready    = (state == RESP);
   assign bus.err      = (state == RESP) && !lat_hit;
   assign dbg_state    = state;

endmodule
